keypad_emulator: RTL and testbench

- Synthesizable 4x4 key-matrix responder: the other end of the keyboard scan interface. The keyboard decoder drives `col` and samples `row`; this block answers.
- A host, either a test sequencer or a self-test/autoplay controller, hands it one key code at a time.
- It emulates press bounce, a stable hold, release bounce and an inter-key gap, then reports completion.
- Used for loopback self-test of the keypad path and for scripted note/operand entry without a physical keypad.

---
 rtl/keypad_emulator.sv | 152 +++++++++++++++
 tb/tb_keypad_emulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 key-matrix responder: presses one latched key with press bounce, stable hold,
// release bounce and an open gap, answering the decoder's column scan on the row lines.
module keypad_emulator #(
   parameter int HOLD_CYCLES   = 50000,
   parameter int BOUNCE_CYCLES = 1000,
   parameter int BOUNCE_PERIOD = 100,
   parameter int GAP_CYCLES    = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       busy,
   output logic       done
);

   localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int MAX_ALL = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);
   localparam int SUB_W   = $clog2(BOUNCE_PERIOD + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
   localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(BOUNCE_PERIOD - 1);
   localparam bit               NO_BOUNCE   = (BOUNCE_CYCLES == 0);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_PRESS   = 3'd1;
   localparam logic [2:0] ST_HOLD    = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SUB_W-1:0] sub_q, sub_d;
   logic             contact_q, contact_d;
   logic [3:0]       code_q, code_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sub_d     = sub_q;
      contact_d = contact_q;
      code_d    = code_q;
      busy_d    = busy_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_valid && ready_q) begin
               code_d    = key_code;
               cnt_d     = '0;
               sub_d     = '0;
               contact_d = 1'b1;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
               state_d   = NO_BOUNCE ? ST_HOLD : ST_PRESS;
            end
         end
         ST_PRESS, ST_RELEASE: begin
            if (cnt_q == BOUNCE_LAST) begin
               cnt_d = '0;
               sub_d = '0;
               if (state_q == ST_PRESS) begin
                  state_d   = ST_HOLD;
                  contact_d = 1'b1;
               end else begin
                  state_d   = ST_GAP;
                  contact_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // A toggle at the phase's final wrap is overridden by the next state's entry value.
               if (sub_q == SUB_LAST) begin
                  sub_d     = '0;
                  contact_d = ~contact_q;
               end else begin
                  sub_d = sub_q + SUB_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d     = '0;
               sub_d     = '0;
               contact_d = 1'b0;
               state_d   = NO_BOUNCE ? ST_GAP : ST_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            sub_d     = '0;
            contact_d = 1'b0;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sub_q     <= '0;
         contact_q <= 1'b0;
         code_q    <= 4'd0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sub_q     <= sub_d;
         contact_q <= contact_d;
         code_q    <= code_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   // Rows answer the column scan combinationally so the decoder sees no added latency.
   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row[gi] = ~(contact_q && (code_q[3:2] == 2'(gi)) && !col[code_q[1:0]]);
   end

   assign key_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed and randomized key presses on a bouncing and a
// bounce-free instance, checked cycle by cycle against a timeline model of one key press.
module tb_keypad_emulator;

   localparam int H = 8;
   localparam int B = 4;
   localparam int P = 1;
   localparam int G = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_code;
   logic [3:0] col;
   logic       valid_a, valid_b;
   logic       ready_a, busy_a, done_a;
   logic       ready_b, busy_b, done_b;
   logic [3:0] row_a, row_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   keypad_emulator #(
      .HOLD_CYCLES(H), .BOUNCE_CYCLES(B), .BOUNCE_PERIOD(P), .GAP_CYCLES(G)
   ) dut_a (
      .clk(clk), .reset(reset), .key_code(key_code), .key_valid(valid_a),
      .key_ready(ready_a), .col(col), .row(row_a), .busy(busy_a), .done(done_a)
   );

   keypad_emulator #(
      .HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(P), .GAP_CYCLES(G)
   ) dut_b (
      .clk(clk), .reset(reset), .key_code(key_code), .key_valid(valid_b),
      .key_ready(ready_b), .col(col), .row(row_b), .busy(busy_b), .done(done_b)
   );

   // Contact level k cycles after the acceptance edge, from the phase lengths alone.
   function automatic bit model_contact(input int k, input int bnc);
      if (k < bnc)               return ((k / P) % 2) == 0;
      else if (k < bnc + H)      return 1'b1;
      else if (k < 2 * bnc + H)  return (((k - bnc - H) / P) % 2) == 1;
      else                       return 1'b0;
   endfunction

   function automatic logic [3:0] model_row(input bit contact, input logic [3:0] code,
                                            input logic [3:0] c);
      logic [3:0] r;
      int         r_idx;
      int         c_idx;
      r_idx = int'(code) / 4;
      c_idx = int'(code) % 4;
      r = 4'b1111;
      if (contact && c[c_idx] == 1'b0) r[r_idx] = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      assert (act === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", name, act, exp);
      end
   endtask

   task automatic set_valid(input int sel, input logic v);
      if (sel != 0) valid_b = v;
      else          valid_a = v;
   endtask

   // Runs one key from acceptance to the done cycle; col_mode 0 fixed, 1 rotating, 2 random.
   task automatic run_key(input int sel, input logic [3:0] code, input int col_mode,
                          input logic [3:0] col_fix, input bit chain,
                          input logic [3:0] next_code, input int abort_at);
      int         bnc;
      int         total;
      logic [3:0] c;
      logic       v;
      bnc   = (sel != 0) ? 0 : B;
      total = 2 * bnc + H + G;
      key_code = code;
      col      = 4'b1111;
      set_valid(sel, 1'b1);
      #1;
      chk("ready_before_accept", (sel != 0) ? ready_b : ready_a, 4'd1);
      chk("busy_before_accept", (sel != 0) ? busy_b : busy_a, 4'd0);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k <= total; k++) begin
         case (col_mode)
            0:       c = col_fix;
            1:       c = ~(4'b0001 << (k % 4));
            default: c = 4'($urandom);
         endcase
         col      = c;
         key_code = chain ? next_code : 4'($urandom);
         v        = chain ? 1'b1 : ((k < total) ? 1'($urandom) : 1'b0);
         set_valid(sel, v);
         #1;
         chk("row", (sel != 0) ? row_b : row_a, model_row(model_contact(k, bnc), code, c));
         chk("busy", (sel != 0) ? busy_b : busy_a, {3'b0, k < total});
         chk("key_ready", (sel != 0) ? ready_b : ready_a, {3'b0, k == total});
         chk("done", (sel != 0) ? done_b : done_a, {3'b0, k == total});
         if (k == abort_at) break;
         if (k < total) @(negedge clk);
      end
      $display("[TB] dut_%s key %0d col_mode %0d%s", (sel != 0) ? "b" : "a", code, col_mode,
               (abort_at >= 0) ? " (interrupted)" : "");
   endtask

   initial begin
      reset    = 1'b0;
      col      = 4'b0000;
      key_code = 4'd6;
      valid_a  = 1'b1;
      valid_b  = 1'b1;

      // Held in reset with every column scanned and a request pending.
      repeat (3) begin
         @(negedge clk);
         chk("rst_row_a", row_a, 4'b1111);
         chk("rst_ready_a", ready_a, 4'd1);
         chk("rst_busy_a", busy_a, 4'd0);
         chk("rst_done_a", done_a, 4'd0);
         chk("rst_row_b", row_b, 4'b1111);
         chk("rst_busy_b", busy_b, 4'd0);
      end
      valid_a = 1'b0;
      valid_b = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      chk("post_rst_busy_a", busy_a, 4'd0);
      chk("post_rst_ready_a", ready_a, 4'd1);
      chk("post_rst_busy_b", busy_b, 4'd0);
      $display("[TB] reset checks complete");

      run_key(0, 4'd6, 0, 4'b1011, 1'b0, 4'd0, -1);
      run_key(0, 4'd6, 1, 4'b0000, 1'b0, 4'd0, -1);
      run_key(0, 4'd3, 2, 4'b0000, 1'b1, 4'd12, -1);
      run_key(0, 4'd12, 2, 4'b0000, 1'b0, 4'd0, -1);

      // Abort key 5 partway through its hold phase.
      run_key(0, 4'd5, 0, 4'b1101, 1'b0, 4'd0, B + 3);
      valid_a = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      chk("abort_row", row_a, 4'b1111);
      chk("abort_busy", busy_a, 4'd0);
      chk("abort_ready", ready_a, 4'd1);
      repeat (3) begin
         @(negedge clk);
         chk("abort_done", done_a, 4'd0);
         chk("abort_row_held", row_a, 4'b1111);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("abort_no_done", done_a, 4'd0);
      run_key(0, 4'($urandom), 2, 4'b0000, 1'b0, 4'd0, -1);

      run_key(1, 4'd6, 0, 4'b1011, 1'b0, 4'd0, -1);
      for (int i = 0; i < 3; i++) run_key(1, 4'($urandom), 2, 4'b0000, 1'b0, 4'd0, -1);
      for (int i = 0; i < 3; i++) run_key(0, 4'($urandom), 2, 4'b0000, 1'b0, 4'd0, -1);

      valid_a = 1'b0;
      valid_b = 1'b0;
      @(negedge clk);
      chk("final_idle_a", ready_a, 4'd1);
      chk("final_idle_b", ready_b, 4'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
